// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. Drives an external combinational
// adder each RUN cycle and folds its sum/carry back into {ACC,Q}.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] shifted;
  logic               run;

  assign run = (state_q == S_RUN);

  // Adder inputs are forced quiet outside RUN.
  assign add_a   = run ? acc_q : '0;
  assign add_b   = (run && q_q[0]) ? m_q : '0;
  assign add_cin = 1'b0;

  // {cout, sum, Q} >> 1: carry lands in ACC's MSB, sum LSB shifts into Q.
  assign shifted = {add_cout, add_sum, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          product_d = shifted;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: models the attached adder, keeps a countdown
// model of the handshake plus arithmetic expectations, and checks every cycle.
module tb_shift_add_multiplier;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           ready, done, add_cin, add_cout;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a, add_b, add_sum;

  int n_chk = 0, n_fail = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // The downstream adder: plain W-bit addition with carry-out.
  assign {add_cout, add_sum} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase counts down from W+1 after an accepted start; 1 means done cycle.
  int             phase = 0;
  logic [W-1:0]   ma, mb;
  logic [2*W-1:0] m_prod = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  = 0;
      m_prod = '0;
    end else if (phase == 0) begin
      if (start) begin
        phase = W + 1;
        ma = a;
        mb = b;
      end
    end else begin
      phase = phase - 1;
      if (phase == 1) m_prod = (2*W)'(ma) * (2*W)'(mb);
    end
  end

  logic chk_en = 1'b0;
  int   done_cnt = 0;
  bit   cout_seen = 0, addb_nz = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, phase == 0);
      chk("done", done, phase == 1);
      chk("product", product, m_prod);
      chk("add_cin", add_cin, 0);
      if (phase >= 2) begin : run_chk
        int it;
        logic [2*W-1:0] pp;
        logic [W-1:0] mask;
        it   = W + 1 - phase;
        mask = W'((1 << it) - 1);
        pp   = ((2*W)'(ma) * (2*W)'(mb & mask)) >> it;
        chk("add_a", add_a, W'(pp));
        chk("add_b", add_b, mb[it] ? ma : '0);
        if (add_cout) cout_seen = 1;
        if (add_b != 0) addb_nz = 1;
      end else begin
        chk("add_a_idle", add_a, 0);
        chk("add_b_idle", add_b, 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 20 && !done; k++) @(negedge clk);
    if (!done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic mul(input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [2*W-1:0] exp, input string nm);
    @(negedge clk);
    start = 1; a = x; b = y;
    @(negedge clk);
    start = 0;
    wait_done(nm);
    chk(nm, product, exp);
    @(negedge clk);
  endtask

  initial begin
    int d0, t0;
    logic [2*W-1:0] ref_p;
    #12 rst_n = 1'b1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk_en = 1'b1;

    mul(4'h3, 4'h5, 8'h0F, "basic_3x5");
    cout_seen = 0;
    mul(4'hF, 4'hF, 8'hE1, "full_FxF");
    chk("cout_seen", cout_seen, 1);
    mul(4'h0, 4'h9, 8'h00, "zero_a");
    addb_nz = 0;
    mul(4'h9, 4'h0, 8'h00, "zero_b");
    chk("addb_all_zero", addb_nz, 0);

    // Second request while busy must be dropped.
    @(negedge clk);
    start = 1; a = 4'd2; b = 4'd3;
    @(negedge clk);
    start = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1; a = 4'd7; b = 4'd7;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_product", product, 8'h06);

    // Asynchronous reset two iterations into a multiply.
    @(negedge clk);
    start = 1; a = 4'hF; b = 4'hF;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_product", product, 0);
    done_cnt = 0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    mul(4'h6, 4'h7, 8'h2A, "after_rst_6x7");

    // Start held high: completions every W+2 cycles.
    @(negedge clk);
    start = 1; a = 4'hA; b = 4'hB;
    t0 = 0;
    d0 = -1;
    for (int r = 0; r < 3; r++) begin
      wait_done("b2b");
      chk("b2b_product", product, 8'h6E);
      if (d0 >= 0) chk("b2b_period", t0 - d0, W + 2);
      d0 = t0;
      @(negedge clk);
      t0++;
      for (int k = 0; k < 20 && !done; k++) begin
        if (r == 2) break;
        @(negedge clk);
        t0++;
      end
    end
    start = 0;
    repeat (W + 3) @(negedge clk);

    // Exhaustive sweep against plain multiplication.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        ref_p = 8'(i * j);
        mul(W'(i), W'(j), ref_p, "sweep");
      end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
